// File: rtl/fifo_mem_pkg.sv
// Shared definitions for the FIFO storage cores.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
package fifo_mem_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } seq_state_t;

  function automatic int calc_nb(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem_clear_seq.sv
// Post-reset clear sequencer: zeroes one word per cycle, then raises init_done.
// Latency: DEPTH cycles after rst deasserts (or one cycle when clearing is disabled).
// Backpressure: none; the owning memory ignores traffic until init_done.
module fifo_mem_clear_seq
  import fifo_mem_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int AW             = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  seq_state_t    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_done <= (state_nxt == ST_READY);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    clr_addr  = cnt;
    case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_READY;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/fifo_ram_be.sv
// Dual-port register-array storage with byte enables, RDW bypass and a 1/2-stage read pipe.
// Latency: rdata/rvalid RD_LATENCY cycles after re; writes visible to reads on the next cycle.
// Backpressure: none; one read and one write per cycle, traffic ignored until init_done.
module fifo_ram_be
  import fifo_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 16,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         we,
  input  logic [calc_nb(DATA_WIDTH, BYTE_WIDTH)-1:0]   wbe,
  input  logic [calc_aw(DEPTH)-1:0]                    waddr,
  input  logic [DATA_WIDTH-1:0]                        wdata,
  input  logic                                         re,
  input  logic [calc_aw(DEPTH)-1:0]                    raddr,
  output logic [DATA_WIDTH-1:0]                        rdata,
  output logic                                         rvalid,
  output logic                                         init_done
);

  localparam int NB = calc_nb(DATA_WIDTH, BYTE_WIDTH);
  localparam int AW = calc_aw(DEPTH);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("fifo_ram_be: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("fifo_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [AW-1:0]         clr_addr;
  logic                  waddr_ok, raddr_ok;
  logic                  wr_ok, rd_ok, hit;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_word;

  fifo_mem_clear_seq #(
    .DEPTH          (DEPTH),
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  // Depth need not be a power of two, so out-of-range addresses are real.
  assign waddr_ok = int'(waddr) < DEPTH;
  assign raddr_ok = int'(raddr) < DEPTH;
  assign wr_ok    = init_done & ~rst & we & waddr_ok;
  assign rd_ok    = init_done & ~rst & re;
  assign hit      = wr_ok & (waddr == raddr);

  always_comb begin
    wr_old    = waddr_ok ? mem[waddr] : '0;
    wr_merged = wr_old;
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) begin
        wr_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      if (WRITE_FIRST == RDW_WRITE_FIRST && hit) begin
        rd_word = wr_merged;
      end else begin
        rd_word = mem[raddr];
      end
    end
  end

  // Storage is deliberately not reset; the clear sequencer owns initial contents.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wr_merged;
    end
  end

  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= rd_ok;
      if (rd_ok) begin
        s1_dat <= rd_word;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_vld;
    logic [DATA_WIDTH-1:0] s2_dat;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld <= 1'b0;
        s2_dat <= '0;
      end else begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_dat <= s1_dat;
        end
      end
    end

    assign rvalid = s2_vld;
    assign rdata  = s2_dat;
  end else begin : g_lat1
    assign rvalid = s1_vld;
    assign rdata  = s1_dat;
  end

endmodule

// File: doc/fifo_ram_be.md
# fifo_ram_be

Parametrised synchronous dual-port register-array memory: the next-generation storage core for the team's FIFOs. Adds per-byte write enables, a qualified read port with valid flag, selectable read latency (1 or 2), selectable read-during-write behaviour, and an optional post-reset clear sequencer. Sits under the FIFO controller, which owns the pointers and full/empty logic; this block owns only storage and the read pipeline.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH
- DEPTH, 16, number of words; any value ≥ 2, power of two not required
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- RD_LATENCY, 1, 1 or 2 cycles from re to rdata/rvalid; other values are an elaboration error
- WRITE_FIRST, 0, 0 = same-address read during write returns old word; 1 = returns newly written (merged) word
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting traffic
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- we  in  1  write enable
- wbe  in  NB  byte-lane enables, lane i = wdata[i*BYTE_WIDTH +: BYTE_WIDTH]
- waddr  in  AW = $clog2(DEPTH)  write address
- wdata  in  DATA_WIDTH  write data
- re  in  1  read enable
- raddr  in  AW  read address
- rdata  out  DATA_WIDTH  registered read data
- rvalid  out  1  rdata carries the result of a read issued RD_LATENCY cycles earlier
- init_done  out  1  memory ready; we/re ignored while low

## Operation
- Reset values: rdata = 0, rvalid = 0, init_done = 0, pipeline stages cleared, clear counter = 0.
- States: CLEAR, READY. rst forces CLEAR (CLEAR_ON_RESET = 1) or READY with init_done low for that cycle (CLEAR_ON_RESET = 0).
- CLEAR: one word zeroed per cycle, address 0 to DEPTH-1; on writing DEPTH-1 go to READY, init_done = 1 from the next cycle. we/re ignored, rvalid stays 0. Memory contents are not reset when CLEAR_ON_RESET = 0.
- rst asserted mid-CLEAR restarts the counter at 0; rst mid-read drops all in-flight reads (rvalid 0 next cycle).
- Write (READY, we = 1): lanes with wbe[i] = 1 updated, others retained; wbe = 0 is a no-op. waddr ≥ DEPTH: write dropped.
- Read (READY, re = 1): mem[raddr] captured; raddr ≥ DEPTH returns 0 with rvalid still 1. re = 0: rvalid 0, rdata holds last value (no update).
- Same-address read and write in one cycle: WRITE_FIRST = 0 returns pre-write word; WRITE_FIRST = 1 returns old word with wbe lanes replaced by wdata.
- Write and read different addresses in one cycle: fully independent.

## Timing
- RD_LATENCY = 1: re at edge N gives rdata/rvalid valid after edge N+1.
- RD_LATENCY = 2: extra output register; valid after edge N+2; stage-2 rdata updates only when stage-1 valid.
- Throughput: one read and one write per cycle, back-to-back, no bubbles.
- Write visible to a read of the same address issued on the following cycle regardless of WRITE_FIRST.
- CLEAR lasts exactly DEPTH cycles after rst deasserts; init_done rises on the cycle after the last clear write.

## Structure
- Shared package fifo_mem_pkg: read-during-write mode constants (RDW_READ_FIRST, RDW_WRITE_FIRST), latency limits, helper function for NB and AW.
- Sub-module fifo_mem_clear_seq: CLEAR/READY FSM, clear counter, init_done; outputs clear address and clear-write strobe muxed into the write port.
- Top holds the array, byte-merge logic, bypass mux, and read pipeline.

## Test plan
- DEPTH=16, CLEAR_ON_RESET=1: pulse rst, count cycles -> init_done rises 16 cycles after rst low; read all addresses -> all 0x0000, rvalid 1 each.
- Write 0xABCD @3 with wbe=2'b11, then wbe=2'b01 data 0x1234 @3, read @3 -> 0xAB34.
- Same cycle write 0x5555 @7 (old 0x1111) and read @7: WRITE_FIRST=0 -> 0x1111; WRITE_FIRST=1 -> 0x5555; next-cycle read -> 0x5555 both.
- RD_LATENCY=2, re every cycle on addresses 0..15 -> rvalid continuous, rdata in address order, first two cycles after first re rvalid 0 then 1.
- DEPTH=12: write @13 and read @13 -> write dropped, rdata 0, rvalid 1; words 0..11 unchanged.
- rst asserted at clear counter 5 -> counter restarts, init_done rises 16 cycles after second rst release; in-flight read returns rvalid 0.
